toggle_pulse_gen: RTL and testbench

Upstream conditioning stage for the T flip-flop built from a JK flip-flop. It takes a raw, asynchronous, bouncing push-button level, synchronises and debounces it, and emits a single-cycle `t_pulse` per accepted press. That pulse drives the T flip-flop's `t` input directly, so one physical press produces exactly one toggle of `q`. It also provides the debounced level and a running count of emitted pulses.

---
 rtl/toggle_pkg.sv | 15 +
 rtl/sync_chain.sv | 27 ++
 rtl/toggle_pulse_gen.sv | 122 ++++++++++++
 tb/tb_toggle_pulse_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and constants for the push-button to T flip-flop pulse generator.
//   tpg_state_t : debounce FSM states
//   PRESS_CNT_W : width of the emitted-pulse counter
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } tpg_state_t;

    localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level.
//   clk : sampling clock
//   rst : asynchronous active-low reset, clears every stage to 0
//   d   : asynchronous input level
//   q   : level synchronised to clk, STAGES cycles later
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/toggle_pulse_gen.sv
// Synchronises and debounces a raw push-button, and emits one single-cycle
// pulse per accepted press to drive a T flip-flop's t input.
//   clk       : sole clock
//   rst       : asynchronous active-low reset
//   btn_in    : raw, asynchronous, possibly bouncing button level
//   enable    : sampled on the press-accepting edge; 0 suppresses the pulse
//   t_pulse   : one-cycle pulse per accepted press
//   btn_level : debounced button level
//   press_cnt : number of emitted pulses, wraps 255 -> 0
module toggle_pulse_gen
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_in,
    input  logic                   enable,
    output logic                   t_pulse,
    output logic                   btn_level,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value held when the next matching sample completes the run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                   w_btn_sync;
    tpg_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_t_pulse;
    logic                   r_btn_level;
    logic [PRESS_CNT_W-1:0] r_press_cnt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (w_btn_sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_t_pulse   <= 1'b0;
            r_btn_level <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            // The pulse only ever lives for the cycle after the accepting edge.
            r_t_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_btn_sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_state     <= PRESSED;
                            r_cnt       <= '0;
                            r_btn_level <= 1'b1;
                            r_t_pulse   <= enable;
                            if (enable) r_press_cnt <= r_press_cnt + PRESS_CNT_W'(1);
                        end else begin
                            r_state <= PRESS_WAIT;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!w_btn_sync) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        // enable is looked at only here, so a held button gives one pulse.
                        r_state     <= PRESSED;
                        r_cnt       <= '0;
                        r_btn_level <= 1'b1;
                        r_t_pulse   <= enable;
                        if (enable) r_press_cnt <= r_press_cnt + PRESS_CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!w_btn_sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_state     <= IDLE;
                            r_cnt       <= '0;
                            r_btn_level <= 1'b0;
                        end else begin
                            r_state <= RELEASE_WAIT;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (w_btn_sync) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_btn_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign t_pulse   = r_t_pulse;
    assign btn_level = r_btn_level;
    assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Integration bench: toggle_pulse_gen driving a T flip-flop model.
// Stimulus pushes the expected pulse (edge number, press_cnt) into a queue;
// a monitor pops and compares whenever t_pulse is seen high.
module tb_toggle_pulse_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic       enable = 1'b1;
    logic       t_pulse;
    logic       btn_level;
    logic [7:0] press_cnt;
    logic       tff_q;

    typedef struct {
        int         edge_no;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         edge_n = 0;
    int         checks = 0;
    int         passes = 0;
    int         pulses_seen = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic       exp_q = 1'b0;
    logic       prev_pulse = 1'b0;

    toggle_pulse_gen dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .enable    (enable),
        .t_pulse   (t_pulse),
        .btn_level (btn_level),
        .press_cnt (press_cnt)
    );

    // T flip-flop fed by t_pulse
    always @(posedge clk or negedge rst) begin
        if (!rst) tff_q <= 1'b0;
        else if (t_pulse) tff_q <= ~tff_q;
    end

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void check(string name, int got, int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_n);
    endfunction

    function automatic void push(int e);
        exp_t x;
        exp_cnt = exp_cnt + 8'd1;
        exp_q   = ~exp_q;
        x.edge_no = e;
        x.cnt     = exp_cnt;
        sb.push_back(x);
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every observed pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (t_pulse) begin
            pulses_seen++;
            check("single_cycle", int'(prev_pulse), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_edge", edge_n, e.edge_no);
                check("pulse_press_cnt", int'(press_cnt), int'(e.cnt));
            end
        end
        if (sb.size() > 0 && sb[0].edge_no < edge_n) begin
            check("missed_pulse", 0, sb[0].edge_no);
            void'(sb.pop_front());
        end
        prev_pulse = t_pulse;
    end

    // Clean press then release, with level latency checks.
    task automatic press_release(bit en);
        int e0;
        int e1;
        e0 = edge_n;
        enable = en;
        btn_in = 1'b1;
        if (en) push(e0 + 6);
        step(5);
        check("press_level_early", int'(btn_level), 0);
        step(1);
        check("press_level", int'(btn_level), 1);
        check("press_cnt_after_accept", int'(press_cnt), int'(exp_cnt));
        // late enable change must not produce a pulse
        enable = 1'b1;
        step(2);
        check("tff_q", int'(tff_q), int'(exp_q));
        e1 = edge_n;
        btn_in = 1'b0;
        step(5);
        check("release_level_early", int'(btn_level), 1);
        step(1);
        check("release_level", int'(btn_level), 0);
        if (edge_n != e1 + 6) check("release_edge", edge_n, e1 + 6);
        step(2);
    endtask

    initial begin
        int e0;
        logic pat_p [6];
        logic pat_r [3];
        pat_p = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        pat_r = '{1'b0, 1'b1, 1'b0};

        // Reset held 3 cycles with button down
        rst = 1'b0;
        btn_in = 1'b1;
        #1;
        check("rst_t_pulse", int'(t_pulse), 0);
        check("rst_btn_level", int'(btn_level), 0);
        check("rst_press_cnt", int'(press_cnt), 0);
        step(3);
        check("rst_hold_btn_level", int'(btn_level), 0);
        check("rst_hold_press_cnt", int'(press_cnt), 0);
        e0 = edge_n;
        rst = 1'b1;
        push(e0 + 6);
        step(6);
        check("rst_rel_level", int'(btn_level), 1);
        check("rst_rel_cnt", int'(press_cnt), 1);
        step(2);
        btn_in = 1'b0;
        step(10);

        // Clean press held 20 cycles
        e0 = edge_n;
        btn_in = 1'b1;
        push(e0 + 6);
        step(5);
        check("clean_level_early", int'(btn_level), 0);
        step(1);
        check("clean_level", int'(btn_level), 1);
        step(14);
        check("clean_level_held", int'(btn_level), 1);
        check("clean_q", int'(tff_q), int'(exp_q));
        check("clean_cnt", int'(press_cnt), int'(exp_cnt));
        btn_in = 1'b0;
        step(10);

        // Bouncing press: last rise before edge e0+6, accepted at e0+11
        e0 = edge_n;
        push(e0 + 11);
        for (int i = 0; i < 6; i++) begin
            btn_in = pat_p[i];
            step(1);
        end
        btn_in = 1'b1;
        step(4);
        check("bounce_level_early", int'(btn_level), 0);
        step(1);
        check("bounce_level", int'(btn_level), 1);
        check("bounce_cnt", int'(press_cnt), int'(exp_cnt));
        step(5);
        // Bouncing release: last fall before edge e0+3, level drops at e0+8
        e0 = edge_n;
        for (int i = 0; i < 3; i++) begin
            btn_in = pat_r[i];
            step(1);
        end
        btn_in = 1'b0;
        step(4);
        check("bounce_rel_level_early", int'(btn_level), 1);
        step(1);
        check("bounce_rel_level", int'(btn_level), 0);
        step(5);

        // Enable low on the accepting edge, then enabled press
        press_release(1'b0);
        check("enable_cnt_unchanged", int'(press_cnt), int'(exp_cnt));
        press_release(1'b1);

        // Wrap: 256 press/release cycles
        pulses_seen = 0;
        for (int i = 0; i < 256; i++) press_release(1'b1);
        check("wrap_pulses", pulses_seen, 256);
        check("wrap_cnt", int'(press_cnt), int'(exp_cnt));

        // Reset while in PRESS_WAIT with cnt=2, button still held
        e0 = edge_n;
        btn_in = 1'b1;
        step(4);
        rst = 1'b0;
        exp_cnt = 8'd0;
        exp_q = 1'b0;
        #1;
        check("mid_rst_t_pulse", int'(t_pulse), 0);
        check("mid_rst_level", int'(btn_level), 0);
        check("mid_rst_cnt", int'(press_cnt), 0);
        check("mid_rst_q", int'(tff_q), 0);
        step(3);
        check("mid_rst_hold_level", int'(btn_level), 0);
        e0 = edge_n;
        rst = 1'b1;
        push(e0 + 6);
        step(8);
        check("mid_rst_redebounce_cnt", int'(press_cnt), 1);
        check("mid_rst_redebounce_q", int'(tff_q), int'(exp_q));
        btn_in = 1'b0;
        step(10);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
